// File: rtl/avg_n_sample_packer.sv
// avg_n_sample_packer: packs serial samples into one vector for the averager and waits for its result
module avg_n_sample_packer #(
  parameter int NUM_INPUTS = 16,
  parameter int DWIDTH     = 16,
  parameter int TIMEOUT    = 100
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DWIDTH-1:0]                i_dat,
  input  logic                             i_dat_valid,
  output logic                             o_dat_ready,
  input  logic                             i_flush,
  output logic [NUM_INPUTS*DWIDTH-1:0]     o_dat_vector,
  output logic                             o_dat_valid,
  input  logic                             i_done,
  output logic                             o_busy,
  output logic [$clog2(NUM_INPUTS+1)-1:0]  o_count,
  output logic                             o_timeout
);
  localparam int CW = $clog2(NUM_INPUTS + 1);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {FILL, EMIT, WAIT} state_t;
  state_t                       state_q, state_d;
  logic [CW-1:0]                count_q, count_d;
  logic [NUM_INPUTS*DWIDTH-1:0] vec_q, vec_d;
  logic [TW-1:0]                wcnt_q, wcnt_d;
  logic                         acc, flush, last, tmo;
  assign flush = state_q == FILL && i_flush;
  assign acc   = state_q == FILL && i_dat_valid && !i_flush;
  assign last  = count_q == CW'(NUM_INPUTS - 1);
  // timeout is decoded from the wait counter alone so o_timeout has no input path
  assign tmo   = TIMEOUT != 0 && state_q == WAIT && wcnt_q == TW'(TIMEOUT);
  assign o_count      = count_q;
  assign o_dat_vector = vec_q;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      vec_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vec_q   <= vec_d;
      wcnt_q  <= wcnt_d;
    end
  end
  // next state: EMIT lasts one cycle and honours an early i_done
  always_comb begin
    state_d = state_q == FILL ? ((acc && last) ? EMIT : FILL) :
              state_q == EMIT ? (i_done ? FILL : WAIT) :
              (i_done || tmo) ? FILL : WAIT;
  end
  // sample count, lane writes and wait counter; flush beats a same-cycle accept
  always_comb begin
    count_d = (state_q != FILL && state_d == FILL) || flush ? '0 :
              acc ? count_q + CW'(1) : count_q;
    vec_d   = vec_q;
    if (acc) vec_d[count_q*DWIDTH +: DWIDTH] = i_dat;
    wcnt_d  = state_d == EMIT ? '0 :
              (state_q == WAIT && wcnt_q != TW'(TIMEOUT)) ? wcnt_q + TW'(1) : wcnt_q;
  end
  // outputs decoded from registered state only
  always_comb begin
    o_dat_ready = state_q == FILL;
    o_dat_valid = state_q == EMIT;
    o_busy      = state_q != FILL;
    o_timeout   = tmo;
  end
endmodule

// File: tb/tb_avg_n_sample_packer.sv
// tb_avg_n_sample_packer: directed checks of fill, emit, wait, flush, timeout and reset
module tb_avg_n_sample_packer;
  localparam int N = 16, DW = 16, TO = 100;
  logic             clk = 0, rst = 1;
  logic [DW-1:0]    i_dat = '0;
  logic             i_dat_valid = 0, i_flush = 0, i_done = 0;
  logic             o_dat_ready, o_dat_valid, o_busy, o_timeout;
  logic [N*DW-1:0]  o_dat_vector;
  logic [4:0]       o_count;
  logic [255:0]     exp_vec;
  int               n_chk = 0, n_fail = 0, n_valid = 0, n_tmo = 0, k;
  avg_n_sample_packer #(.NUM_INPUTS(N), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_dat(i_dat), .i_dat_valid(i_dat_valid),
    .o_dat_ready(o_dat_ready), .i_flush(i_flush), .o_dat_vector(o_dat_vector),
    .o_dat_valid(o_dat_valid), .i_done(i_done), .o_busy(o_busy),
    .o_count(o_count), .o_timeout(o_timeout)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (o_dat_valid) n_valid++;
    if (o_timeout) n_tmo++;
  end
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input logic [DW-1:0] d);
    i_dat = d;
    i_dat_valid = 1;
    step();
    i_dat_valid = 0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, " ready"}, o_dat_ready, 1);
    check({tag, " valid"}, o_dat_valid, 0);
    check({tag, " busy"}, o_busy, 0);
    check({tag, " count"}, o_count, 0);
    check({tag, " timeout"}, o_timeout, 0);
  endtask
  initial begin
    step();
    step();
    check_idle("reset");
    check("reset vector", o_dat_vector, 0);
    rst = 0;
    // back-to-back fill, i_done three cycles after the valid pulse
    for (int i = 0; i < N; i++) begin
      feed(DW'(i + 1));
      if (i < N - 1) check("t1 count", o_count, i + 1);
    end
    check("t1 emit valid", o_dat_valid, 1);
    check("t1 emit ready", o_dat_ready, 0);
    check("t1 emit busy", o_busy, 1);
    check("t1 emit count", o_count, N);
    check("t1 lane0", o_dat_vector[0 +: DW], 16'h0001);
    check("t1 lane15", o_dat_vector[15*DW +: DW], 16'h0010);
    step();
    check("t1 wait valid", o_dat_valid, 0);
    check("t1 wait ready", o_dat_ready, 0);
    check("t1 wait busy", o_busy, 1);
    step();
    step();
    i_done = 1;
    check("t1 ready before done", o_dat_ready, 0);
    step();
    i_done = 0;
    check_idle("t1 after done");
    check("t1 pulses", n_valid, 1);
    // flush with a same-cycle sample, then gapped refill and i_done during EMIT
    for (int i = 0; i < 5; i++) feed(DW'(16'h00a0 + i));
    check("t3 count5", o_count, 5);
    i_dat = 16'hbeef;
    i_dat_valid = 1;
    i_flush = 1;
    step();
    i_dat_valid = 0;
    i_flush = 0;
    check("t3 flush count", o_count, 0);
    exp_vec = '0;
    for (int i = 0; i < N; i++) begin
      exp_vec[i*DW +: DW] = DW'(16'h0100 + i);
      feed(DW'(16'h0100 + i));
      if (i < N - 1) begin
        step();
        check("t3 gap count", o_count, i + 1);
      end
    end
    check("t3 emit valid", o_dat_valid, 1);
    check("t3 vector", o_dat_vector, exp_vec);
    i_done = 1;
    step();
    i_done = 0;
    check_idle("t5 emit done");
    check("t5 vector held", o_dat_vector, exp_vec);
    check("t3 pulses", n_valid, 2);
    // no i_done: timeout, with samples offered during WAIT ignored
    for (int i = 0; i < N; i++) feed(DW'(16'h0200 + i));
    check("t4 emit valid", o_dat_valid, 1);
    i_dat = 16'hdead;
    i_dat_valid = 1;
    k = 0;
    do begin
      step();
      k++;
    end while (!o_timeout && k < 300);
    check("t4 timeout latency", k, TO + 1);
    check("t4 timeout ready", o_dat_ready, 0);
    check("t4 wait count", o_count, N);
    i_dat_valid = 0;
    step();
    check_idle("t4 after timeout");
    check("t4 lane0 kept", o_dat_vector[0 +: DW], 16'h0200);
    check("t4 timeout pulses", n_tmo, 1);
    check("t4 valid pulses", n_valid, 3);
    // reset after a partial vector and during WAIT
    for (int i = 0; i < 9; i++) feed(DW'(16'h0300 + i));
    check("t6 count9", o_count, 9);
    rst = 1;
    step();
    rst = 0;
    check_idle("t6 partial reset");
    check("t6 vector cleared", o_dat_vector, 0);
    for (int i = 0; i < N; i++) feed(DW'(16'h0400 + i));
    step();
    check("t6 in wait", o_busy, 1);
    rst = 1;
    step();
    rst = 0;
    check_idle("t6 wait reset");
    i_done = 1;
    feed(16'h0077);
    i_done = 0;
    check("t6 lane0", o_dat_vector[0 +: DW], 16'h0077);
    check("t6 count1", o_count, 1);
    check("t6 busy", o_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
